dcache_controller: RTL and testbench

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

---
 rtl/dcache_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_dcache_controller.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module   : dcache_controller
// Function : Data cache controller with zero-latency hits, dirty-victim
//            writeback, line refill and a sticky memory timeout flag.
// Revision : 1.0
// ============================================================================
module dcache_controller #(
   parameter int MEM_LAT_MAX = 1023
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         cpu_req_i,
   input  logic         cpu_we_i,
   input  logic [31:0]  cpu_addr_i,
   input  logic [31:0]  cpu_data_i,
   output logic [31:0]  cpu_data_o,
   output logic         cpu_stall_o,
   output logic         sram_enable_o,
   output logic         sram_write_o,
   output logic [3:0]   sram_addr_o,
   output logic [24:0]  sram_tag_o,
   output logic [255:0] sram_data_o,
   input  logic         sram_hit_i,
   input  logic [24:0]  sram_tag_i,
   input  logic [255:0] sram_data_i,
   output logic         mem_enable_o,
   output logic         mem_write_o,
   output logic [31:0]  mem_addr_o,
   output logic [255:0] mem_data_o,
   input  logic [255:0] mem_data_i,
   input  logic         mem_ack_i,
   output logic [15:0]  miss_cnt_o,
   output logic [15:0]  wb_cnt_o,
   output logic         timeout_o
);

   localparam int                  c_WAIT_W   = $clog2(MEM_LAT_MAX + 1);
   localparam logic [c_WAIT_W-1:0] c_LAT_MAX  = c_WAIT_W'(MEM_LAT_MAX);
   localparam logic [c_WAIT_W-1:0] c_LAT_LAST = c_WAIT_W'(MEM_LAT_MAX - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_MISS      = 3'd1,
      S_WRITEBACK = 3'd2,
      S_REFILL    = 3'd3,
      S_UPDATE    = 3'd4
   } state_t;

   state_t              r_state;
   logic [26:0]         r_line_addr;
   logic [24:0]         r_victim_tag;
   logic [255:0]        r_victim_line;
   logic [255:0]        r_refill_line;
   logic                r_mem_en;
   logic                r_mem_we;
   logic [31:0]         r_mem_addr;
   logic [255:0]        r_mem_data;
   logic [15:0]         r_miss_cnt;
   logic [15:0]         r_wb_cnt;
   logic [c_WAIT_W-1:0] r_wait;
   logic                r_timeout;

   logic [22:0]  w_tag;
   logic [3:0]   w_index;
   logic [2:0]   w_word;
   logic         w_ack;
   logic         w_waiting;
   logic [255:0] w_wr_line;
   logic         w_unused;

   assign w_tag    = cpu_addr_i[31:9];
   assign w_index  = cpu_addr_i[8:5];
   assign w_word   = cpu_addr_i[4:2];
   assign w_unused = &{1'b0, cpu_addr_i[1:0]};

   // An ack only counts while a memory transaction is actually being presented.
   assign w_ack     = mem_ack_i & r_mem_en;
   assign w_waiting = ((r_state == S_WRITEBACK) || (r_state == S_REFILL)) && !w_ack;

   assign mem_enable_o = r_mem_en;
   assign mem_write_o  = r_mem_we;
   assign mem_addr_o   = r_mem_addr;
   assign mem_data_o   = r_mem_data;
   assign miss_cnt_o   = r_miss_cnt;
   assign wb_cnt_o     = r_wb_cnt;
   assign timeout_o    = r_timeout;

   always_comb begin
      w_wr_line = sram_data_i;
      w_wr_line[32*w_word +: 32] = cpu_data_i;
   end

   // Array-side and CPU-side outputs; forced quiet while reset is asserted.
   always_comb begin
      sram_enable_o = 1'b0;
      sram_write_o  = 1'b0;
      sram_addr_o   = '0;
      sram_tag_o    = '0;
      sram_data_o   = '0;
      cpu_stall_o   = 1'b0;
      cpu_data_o    = '0;
      if (!rst_i) begin
         case (r_state)
            S_IDLE: begin
               if (cpu_req_i) begin
                  sram_enable_o = 1'b1;
                  sram_addr_o   = w_index;
                  sram_tag_o    = {2'b10, w_tag};
                  if (sram_hit_i) begin
                     cpu_data_o = sram_data_i[32*w_word +: 32];
                     if (cpu_we_i) begin
                        sram_write_o = 1'b1;
                        sram_data_o  = w_wr_line;
                        sram_tag_o   = {2'b11, w_tag};
                     end
                  end else begin
                     cpu_stall_o = 1'b1;
                  end
               end
            end
            S_UPDATE: begin
               sram_enable_o = 1'b1;
               sram_write_o  = 1'b1;
               sram_addr_o   = r_line_addr[3:0];
               sram_tag_o    = {2'b10, r_line_addr[26:4]};
               sram_data_o   = r_refill_line;
               cpu_stall_o   = 1'b1;
            end
            default: begin
               cpu_stall_o = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state       <= S_IDLE;
         r_line_addr   <= '0;
         r_victim_tag  <= '0;
         r_victim_line <= '0;
         r_refill_line <= '0;
         r_mem_en      <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_data    <= '0;
         r_miss_cnt    <= '0;
         r_wb_cnt      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cpu_req_i && !sram_hit_i) begin
                  r_line_addr   <= cpu_addr_i[31:5];
                  r_victim_tag  <= sram_tag_i;
                  r_victim_line <= sram_data_i;
                  if (r_miss_cnt != 16'hFFFF) begin
                     r_miss_cnt <= r_miss_cnt + 16'd1;
                  end
                  r_state <= S_MISS;
               end
            end
            S_MISS: begin
               r_mem_en <= 1'b1;
               if (r_victim_tag[24] && r_victim_tag[23]) begin
                  r_mem_we   <= 1'b1;
                  r_mem_addr <= {r_victim_tag[22:0], r_line_addr[3:0], 5'b0};
                  r_mem_data <= r_victim_line;
                  r_state    <= S_WRITEBACK;
               end else begin
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= {r_line_addr, 5'b0};
                  r_state    <= S_REFILL;
               end
            end
            S_WRITEBACK: begin
               if (w_ack) begin
                  r_mem_en <= 1'b0;
                  r_mem_we <= 1'b0;
                  if (r_wb_cnt != 16'hFFFF) begin
                     r_wb_cnt <= r_wb_cnt + 16'd1;
                  end
                  r_state <= S_REFILL;
               end
            end
            S_REFILL: begin
               // Arriving from a writeback, enable is low for one idle cycle first.
               if (!r_mem_en) begin
                  r_mem_en   <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= {r_line_addr, 5'b0};
               end else if (w_ack) begin
                  r_mem_en      <= 1'b0;
                  r_refill_line <= mem_data_i;
                  r_state       <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wait    <= '0;
         r_timeout <= 1'b0;
      end else if (!w_waiting) begin
         r_wait <= '0;
      end else begin
         if (r_wait != c_LAT_MAX) begin
            r_wait <= r_wait + 1'b1;
         end
         if (r_wait == c_LAT_LAST) begin
            r_timeout <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_controller
// Function : Self-checking bench: array and memory models, table of accesses
//            with a read-data scoreboard, plus reset/timeout sequences.
// Revision : 1.0
// ============================================================================
module tb_dcache_controller;

   localparam int c_LAT = 16;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         cpu_req_i, cpu_we_i;
   logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
   logic         cpu_stall_o;
   logic         sram_enable_o, sram_write_o;
   logic [3:0]   sram_addr_o;
   logic [24:0]  sram_tag_o;
   logic [255:0] sram_data_o;
   logic         sram_hit_i;
   logic [24:0]  sram_tag_i;
   logic [255:0] sram_data_i;
   logic         mem_enable_o, mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;
   logic [15:0]  miss_cnt_o, wb_cnt_o;
   logic         timeout_o;

   logic         r_model_ack = 1'b0;
   logic         r_tb_ack = 1'b0;
   assign mem_ack_i = r_model_ack | r_tb_ack;

   always #5 clk_i = ~clk_i;

   dcache_controller #(.MEM_LAT_MAX(c_LAT)) u_dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
      .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
      .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
      .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
      .sram_hit_i(sram_hit_i), .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .miss_cnt_o(miss_cnt_o), .wb_cnt_o(wb_cnt_o), .timeout_o(timeout_o)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_line(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] f_init(input logic [31:0] a);
      return (a * 32'd65539) ^ 32'h5EED1234;
   endfunction

   function automatic logic [255:0] f_init_line(input logic [26:0] la);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) begin
         logic [2:0] wi;
         wi = 3'(w);
         l[32*w +: 32] = f_init({la, wi, 2'b00});
      end
      return l;
   endfunction

   // ---------------- reference word model + read scoreboard ----------------
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] sb_q [$];

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [31:0] k;
      k = {a[31:2], 2'b00};
      if (ref_mem.exists(k)) return ref_mem[k];
      return f_init(k);
   endfunction

   // ---------------- cache array model ----------------
   logic [24:0]  sr_tag  [16];
   logic [255:0] sr_data [16];
   logic         bd_en = 1'b0, bd_clr = 1'b0;
   logic [3:0]   bd_idx = '0;
   logic [24:0]  bd_tag = '0;
   logic [255:0] bd_line = '0;

   always_comb begin
      sram_tag_i  = sr_tag[sram_addr_o];
      sram_data_i = sr_data[sram_addr_o];
      sram_hit_i  = sr_tag[sram_addr_o][24] && (sr_tag[sram_addr_o][22:0] == sram_tag_o[22:0]);
   end

   always @(posedge clk_i) begin
      if (bd_clr) begin
         for (int i = 0; i < 16; i++) begin
            sr_tag[i]  <= '0;
            sr_data[i] <= '0;
         end
      end else if (bd_en) begin
         sr_tag[bd_idx]  <= bd_tag;
         sr_data[bd_idx] <= bd_line;
      end else if (sram_enable_o && sram_write_o) begin
         sr_tag[sram_addr_o]  <= sram_tag_o;
         sr_data[sram_addr_o] <= sram_data_o;
      end
   end

   task automatic backdoor(input logic [3:0] idx, input logic [24:0] tag, input logic [255:0] line);
      bd_idx = idx; bd_tag = tag; bd_line = line; bd_en = 1'b1;
      @(posedge clk_i); #1;
      bd_en = 1'b0;
   endtask

   // ---------------- memory model ----------------
   logic [255:0] mem_store [logic [26:0]];
   int           ack_delay = 3;
   int           en_cnt = 0;
   int           n_mem_txn = 0;
   logic [31:0]  txn_addr = '0, last_wr_addr = '0, last_rd_addr = '0;
   logic [255:0] last_wr_data = '0;

   initial mem_data_i = '0;

   always @(negedge clk_i) begin
      if (mem_enable_o) begin
         if (en_cnt == 0) txn_addr = mem_addr_o;
         en_cnt++;
         if (en_cnt == ack_delay) begin
            chk("mem_addr_stable", mem_addr_o, txn_addr);
            n_mem_txn++;
            if (mem_write_o) begin
               mem_store[mem_addr_o[31:5]] = mem_data_o;
               last_wr_addr = mem_addr_o;
               last_wr_data = mem_data_o;
            end else begin
               mem_data_i = mem_store.exists(mem_addr_o[31:5]) ? mem_store[mem_addr_o[31:5]]
                                                               : f_init_line(mem_addr_o[31:5]);
               last_rd_addr = mem_addr_o;
            end
            r_model_ack = 1'b1;
         end else begin
            r_model_ack = 1'b0;
         end
      end else begin
         en_cnt = 0;
         r_model_ack = 1'b0;
      end
   end

   // ---------------- CPU access task ----------------
   task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             output int stalls);
      cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wd;
      if (we) ref_mem[{addr[31:2], 2'b00}] = wd;
      else    sb_q.push_back(ref_word(addr));
      stalls = 0;
      @(negedge clk_i);
      while (cpu_stall_o && stalls < 200) begin
         stalls++;
         @(negedge clk_i);
      end
      chk("access_done", 32'(cpu_stall_o), 32'd0);
      if (!we) begin
         if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
         else                  chk("rd_data", cpu_data_o, sb_q.pop_front());
      end
      @(posedge clk_i); #1;
      cpu_req_i = 1'b0; cpu_we_i = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      int          exp_stall;
   } vec_t;

   vec_t vecs [10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int           st;
      int           n_before;
      int           n_en;
      logic         t16, t17;
      logic [255:0] dl;
      logic [31:0]  exp_rd;

      vecs[0] = '{we:1'b0, addr:32'h0000_0A08, wd:32'h0,         exp_stall:5};
      vecs[1] = '{we:1'b1, addr:32'h0000_0A0C, wd:32'h1111_2222, exp_stall:0};
      vecs[2] = '{we:1'b0, addr:32'h0000_0A0C, wd:32'h0,         exp_stall:0};
      vecs[3] = '{we:1'b0, addr:32'h0000_1010, wd:32'h0,         exp_stall:8};
      vecs[4] = '{we:1'b0, addr:32'h0000_0A0C, wd:32'h0,         exp_stall:5};
      vecs[5] = '{we:1'b1, addr:32'h0001_23F4, wd:32'hA5A5_0F0F, exp_stall:5};
      vecs[6] = '{we:1'b0, addr:32'h0001_23F4, wd:32'h0,         exp_stall:0};
      vecs[7] = '{we:1'b0, addr:32'h0000_2468, wd:32'h0,         exp_stall:0};
      vecs[8] = '{we:1'b0, addr:32'h0000_4460, wd:32'h0,         exp_stall:8};
      vecs[9] = '{we:1'b0, addr:32'h0000_247C, wd:32'h0,         exp_stall:5};

      cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
      rst_i = 1'b1; bd_clr = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0; bd_clr = 1'b0;

      // reset state
      @(negedge clk_i);
      chk("rst_stall", 32'(cpu_stall_o), 32'd0);
      chk("rst_mem_en", 32'(mem_enable_o), 32'd0);
      chk("rst_sram_en", 32'(sram_enable_o), 32'd0);
      chk("rst_miss_cnt", 32'(miss_cnt_o), 32'd0);
      chk("rst_wb_cnt", 32'(wb_cnt_o), 32'd0);
      chk("rst_timeout", 32'(timeout_o), 32'd0);
      @(posedge clk_i); #1;

      // read hit on a preloaded line
      backdoor(4'd3, {2'b10, 23'h12}, f_init_line(27'h123));
      n_before = n_mem_txn;
      cpu_access(1'b0, 32'h0000_2468, 32'h0, st);
      chk("hit_stall", 32'(st), 32'd0);
      chk("hit_no_mem", 32'(n_mem_txn), 32'(n_before));
      chk("hit_miss_cnt", 32'(miss_cnt_o), 32'd0);

      // clean read miss, ack on fifth cycle
      ack_delay = 5;
      cpu_access(1'b0, 32'h0000_0200, 32'h0, st);
      chk("clean_stall", 32'(st), 32'd8);
      chk("clean_rd_addr", last_rd_addr, 32'h0000_0200);
      chk("clean_miss_cnt", 32'(miss_cnt_o), 32'd1);
      chk("clean_wb_cnt", 32'(wb_cnt_o), 32'd0);

      // write hit to word 7
      cpu_access(1'b1, 32'h0000_247C, 32'hDEAD_BEEF, st);
      chk("wr_hit_stall", 32'(st), 32'd0);
      chk("wr_hit_word", sr_data[3][255:224], 32'hDEAD_BEEF);
      chk("wr_hit_tag", 32'(sr_tag[3]), 32'({2'b11, 23'h12}));

      // dirty victim at index 0
      for (int w = 0; w < 8; w++) begin
         dl[32*w +: 32] = 32'hC0DE_0000 + 32'(w);
         ref_mem[32'h0000_0A00 + 32'(4*w)] = 32'hC0DE_0000 + 32'(w);
      end
      backdoor(4'd0, {2'b11, 23'h5}, dl);
      ack_delay = 3;
      cpu_access(1'b0, 32'h0000_0004, 32'h0, st);
      chk("dirty_stall", 32'(st), 32'd10);
      chk("dirty_wb_addr", last_wr_addr, 32'h0000_0A00);
      chk_line("dirty_wb_data", last_wr_data, dl);
      chk("dirty_rd_addr", last_rd_addr, 32'h0000_0000);
      chk("dirty_wb_cnt", 32'(wb_cnt_o), 32'd1);
      chk("dirty_miss_cnt", 32'(miss_cnt_o), 32'd2);

      // table of mixed accesses
      ack_delay = 2;
      for (int i = 0; i < 10; i++) begin
         cpu_access(vecs[i].we, vecs[i].addr, vecs[i].wd, st);
         chk($sformatf("vec%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
      end
      chk("tbl_miss_cnt", 32'(miss_cnt_o), 32'd8);
      chk("tbl_wb_cnt", 32'(wb_cnt_o), 32'd3);

      // request dropped while stalled: line still installed
      ack_delay = 4;
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_3040;
      repeat (2) begin @(posedge clk_i); #1; end
      cpu_req_i = 1'b0;
      for (int c = 0; c < 50 && sr_tag[2] !== {2'b10, 23'h18}; c++) @(posedge clk_i);
      #1;
      chk("drop_tag", 32'(sr_tag[2]), 32'({2'b10, 23'h18}));
      chk_line("drop_line", sr_data[2], f_init_line(27'h182));
      @(negedge clk_i);
      chk("drop_idle_stall", 32'(cpu_stall_o), 32'd0);
      chk("drop_miss_cnt", 32'(miss_cnt_o), 32'd9);
      @(posedge clk_i); #1;

      // reset mid-refill, then a late ack
      ack_delay = 1000;
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_5060;
      for (int c = 0; c < 20 && !mem_enable_o; c++) @(negedge clk_i);
      @(negedge clk_i);
      chk("abort_in_refill", 32'(mem_enable_o), 32'd1);
      rst_i = 1'b1;
      #1;
      chk("abort_mem_en", 32'(mem_enable_o), 32'd0);
      chk("abort_stall", 32'(cpu_stall_o), 32'd0);
      chk("abort_miss_cnt", 32'(miss_cnt_o), 32'd0);
      cpu_req_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      r_tb_ack = 1'b1;
      @(posedge clk_i); #1;
      r_tb_ack = 1'b0;
      @(negedge clk_i);
      chk("late_ack_mem_en", 32'(mem_enable_o), 32'd0);
      chk("late_ack_stall", 32'(cpu_stall_o), 32'd0);
      @(posedge clk_i); #1;
      ack_delay = 2;
      cpu_access(1'b0, 32'h0000_247C, 32'h0, st);
      chk("post_rst_hit_stall", 32'(st), 32'd0);
      chk("post_rst_miss_cnt", 32'(miss_cnt_o), 32'd0);

      // withheld ack: timeout after MEM_LAT_MAX refill cycles, then normal completion
      ack_delay = 22;
      n_en = 0; t16 = 1'bx; t17 = 1'bx;
      exp_rd = ref_word(32'h0000_6080);
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_6080;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk_i);
         if (!cpu_stall_o) break;
         if (mem_enable_o) begin
            n_en++;
            if (n_en == 16) t16 = timeout_o;
            if (n_en == 17) t17 = timeout_o;
         end
      end
      chk("to_done", 32'(cpu_stall_o), 32'd0);
      chk("to_before", 32'(t16), 32'd0);
      chk("to_after", 32'(t17), 32'd1);
      chk("to_rd_data", cpu_data_o, exp_rd);
      chk("to_sticky", 32'(timeout_o), 32'd1);
      chk("to_miss_cnt", 32'(miss_cnt_o), 32'd1);
      @(posedge clk_i); #1;
      cpu_req_i = 1'b0;
      repeat (2) @(posedge clk_i);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
